gcd_engine: RTL and testbench
=============================

Name: gcd_engine

Overview:
- Iterative subtractive-Euclid GCD compute stage.
- Sits directly downstream of the operand-issuing master:
  - Accepts an operand pair on a request.
  - Holds busy_o high while it computes.
  - Returns the result with a one-cycle valid_o strobe; the master gates result_val_o with that strobe.
- One operation in flight at a time; no queueing.

Parameters:
- WIDTH, 4, operand and result bit width (unsigned).

Ports:
- clk_i  input  1  single clock; all state updates on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  1  operand request; sampled only in IDLE.
- a_i  input  WIDTH  operand A; captured on acceptance.
- b_i  input  WIDTH  operand B; captured on acceptance.
- busy_o  output  1  high whenever state != IDLE.
- valid_o  output  1  one-cycle strobe: result_o is new this cycle.
- result_o  output  WIDTH  last computed GCD; held until the next completion.

Behaviour:
- Interface is fixed as follows: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: state=IDLE, busy_o=0, valid_o=0, result_o=0, internal op_a/op_b=0.
  - Reset wins over every other event, including mid-CALC or DONE.
  - The in-flight operation is discarded; no valid_o pulse follows.
- States: IDLE, CALC, DONE. All outputs are registered or decoded from state only; no combinational path from req_i/a_i/b_i to outputs.
- IDLE:
  - busy_o=0.
  - If req_i=1 at an edge: op_a<=a_i, op_b<=b_i, go to CALC. That edge is the "acceptance edge", edge 0.
  - If req_i=0: stay in IDLE.
- CALC (busy_o=1), evaluated on the registered op_a/op_b each edge:
  - op_a==0: result_o<=op_b, go to DONE.
  - else op_b==0: result_o<=op_a, go to DONE.
  - else op_a==op_b: result_o<=op_a, go to DONE.
  - else op_a>op_b: op_a<=op_a-op_b.
  - else op_b<=op_b-op_a.
  - Subtraction always takes larger minus smaller, so it never underflows; WIDTH-bit unsigned, no carry out.
- DONE:
  - busy_o=1, valid_o=1 for exactly this one cycle; then go to IDLE.
  - valid_o is never high for two consecutive cycles.
- Latency: with N = number of subtraction steps, valid_o is high in the cycle between edge N+1 and edge N+2 after the acceptance edge.
  - Worst case is N = 2^WIDTH-2 (operands (2^WIDTH-1, 1)).
- Earliest re-acceptance: req_i is sampled again at the edge that leaves DONE? No: that edge moves DONE->IDLE, so the next acceptance is the following edge. Minimum spacing between acceptance edges is N+3.
- req_i high while busy: ignored, not queued. a_i/b_i may change freely after the acceptance edge.
- Zero operands: gcd(0,x)=x, gcd(x,0)=x, gcd(0,0)=0, each with N=0.
- result_o changes only on the edge entering DONE or on reset. It stays stable through IDLE and the next CALC.

Test Plan:
- Reset, then req_i=1, a_i=12, b_i=8 at edge 0:
  - busy_o=1 from edge 0.
  - Sequence (12,8)->(4,8)->(4,4), N=2.
  - valid_o=1 only between edges 3 and 4, result_o=4; busy_o=0 after edge 4.
- a_i=15, b_i=1 (worst case):
  - N=14; valid_o pulses once between edges 15 and 16, result_o=1.
  - Toggling req_i and a_i/b_i during CALC has no effect on the result.
- Boundary operands, each case N=0 and valid between edges 1 and 2:
  - (0,9) -> result_o=9.
  - (9,0) -> result_o=9.
  - (0,0) -> result_o=0.
  - (7,7) -> result_o=7.
- Back-to-back: hold req_i=1 continuously with (6,9) then (10,4).
  - First result 3: N=2, valid between edges 3 and 4.
  - Second request accepted at edge 5; result 2 with N=3, valid between edges 9 and 10.
  - result_o holds 3 until edge 9.
- Reset mid-operation: accept (15,1), assert rst_i at edge 5.
  - After edge 5: busy_o=0, valid_o=0, result_o=0.
  - No valid_o pulse ever appears for the aborted operation.
  - A subsequent (8,12) request completes normally with result_o=4.

Source files
------------

// File: rtl/gcd_engine.sv
// gcd_engine: iterative subtractive-Euclid GCD stage, one operation in flight.
//   clk_i    - clock, all state updates on rising edge
//   rst_i    - synchronous active-high reset
//   req_i    - operand request, sampled only while idle
//   a_i, b_i - operands, captured on acceptance
//   busy_o   - high whenever not idle
//   valid_o  - one-cycle strobe marking a fresh result_o
//   result_o - last computed GCD, held until the next completion
module gcd_engine #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_result;
    logic             w_finish;
    // Any zero operand or equal operands ends the iteration; the answer is
    // op_b when op_a is zero and op_a otherwise (covers gcd(0,0)=0 too).
    assign w_finish = (r_op_a == '0) || (r_op_b == '0) || (r_op_a == r_op_b);
    assign busy_o   = r_state != S_IDLE;
    assign valid_o  = r_state == S_DONE;
    assign result_o = r_result;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (req_i) begin
                    r_op_a  <= a_i;
                    r_op_b  <= b_i;
                    r_state <= S_CALC;
                end
                S_CALC: if (w_finish) begin
                    r_result <= (r_op_a == '0) ? r_op_b : r_op_a;
                    r_state  <= S_DONE;
                end else if (r_op_a > r_op_b) begin
                    r_op_a <= r_op_a - r_op_b;
                end else begin
                    r_op_b <= r_op_b - r_op_a;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: randomized self-checking bench for gcd_engine against a division-based Euclid model.
module tb_gcd_engine;
    localparam int W = 4;
    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         valid;
    logic [W-1:0] res;
    int           passed = 0;
    int           total = 0;
    logic [W-1:0] last_res;
    always #5 clk = ~clk;
    gcd_engine #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .a_i(a), .b_i(b),
        .busy_o(busy), .valid_o(valid), .result_o(res)
    );
    function automatic int model_gcd(input int x, input int y);
        int p, q, r;
        p = x;
        q = y;
        while (q != 0) begin
            r = p % q;
            p = q;
            q = r;
        end
        return p;
    endfunction
    // Subtractive Euclid performs quotient-many subtractions per division step,
    // except the last, which stops at equality one step early.
    function automatic int model_steps(input int x, input int y);
        int hi, lo, r, s;
        if (x == 0 || y == 0) return 0;
        hi = (x > y) ? x : y;
        lo = (x > y) ? y : x;
        s = 0;
        while (lo != 0) begin
            s += hi / lo;
            r = hi % lo;
            hi = lo;
            lo = r;
        end
        return s - 1;
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_op(input int x, input int y, input bit junk);
        int n;
        logic [W-1:0] g;
        logic eb, ev;
        logic [W-1:0] er;
        n = model_steps(x, y);
        g = W'(model_gcd(x, y));
        req = 1'b1;
        a = W'(x);
        b = W'(y);
        tick;
        for (int e = 0; e <= n + 2; e++) begin
            eb = (e <= n + 1);
            ev = (e == n + 1);
            er = (e >= n + 1) ? g : last_res;
            total++;
            if ({busy, valid, res} !== {eb, ev, er})
                $display("FAIL op(%0d,%0d) edge %0d: got busy=%b valid=%b result=%0d, want busy=%b valid=%b result=%0d",
                         x, y, e, busy, valid, res, eb, ev, er);
            else passed++;
            if (e < n + 2) begin
                req = junk ? 1'($urandom_range(0, 1)) : 1'b0;
                if (junk) begin
                    a = W'($urandom);
                    b = W'($urandom);
                end
                tick;
            end
        end
        req = 1'b0;
        last_res = g;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        req = 1'b0;
        a = '0;
        b = '0;
        tick;
        tick;
        total++;
        if ({busy, valid, res} !== {1'b0, 1'b0, W'(0)})
            $display("FAIL reset: got busy=%b valid=%b result=%0d, want 0 0 0", busy, valid, res);
        else passed++;
        rst = 1'b0;
        last_res = '0;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if ({busy, valid} !== 2'b00)
                $display("FAIL idle_no_req: got busy=%b valid=%b, want 0 0", busy, valid);
            else passed++;
        end
    endtask
    task automatic test_basic;
        do_op(12, 8, 1'b0);
        do_op(15, 1, 1'b1);
    endtask
    task automatic test_boundary;
        do_op(0, 9, 1'b0);
        do_op(9, 0, 1'b0);
        do_op(0, 0, 1'b0);
        do_op(7, 7, 1'b0);
        do_op(15, 15, 1'b1);
        do_op(0, 15, 1'b1);
    endtask
    task automatic test_back_to_back;
        int n1, n2, s2;
        logic [W-1:0] g1, g2, er;
        logic eb, ev;
        n1 = model_steps(6, 9);
        n2 = model_steps(10, 4);
        g1 = W'(model_gcd(6, 9));
        g2 = W'(model_gcd(10, 4));
        s2 = n1 + 3;
        req = 1'b1;
        a = 4'd6;
        b = 4'd9;
        tick;
        a = 4'd10;
        b = 4'd4;
        for (int e = 0; e <= s2 + n2 + 2; e++) begin
            if (e <= n1 + 2) begin
                eb = (e <= n1 + 1);
                ev = (e == n1 + 1);
                er = (e >= n1 + 1) ? g1 : last_res;
            end else begin
                eb = (e <= s2 + n2 + 1);
                ev = (e == s2 + n2 + 1);
                er = (e >= s2 + n2 + 1) ? g2 : g1;
            end
            total++;
            if ({busy, valid, res} !== {eb, ev, er})
                $display("FAIL back_to_back edge %0d: got busy=%b valid=%b result=%0d, want busy=%b valid=%b result=%0d",
                         e, busy, valid, res, eb, ev, er);
            else passed++;
            if (e < s2 + n2 + 2) tick;
        end
        req = 1'b0;
        last_res = g2;
    endtask
    task automatic test_reset_mid;
        int seen;
        req = 1'b1;
        a = 4'd15;
        b = 4'd1;
        tick;
        req = 1'b0;
        for (int e = 1; e < 5; e++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++;
        if ({busy, valid, res} !== {1'b0, 1'b0, W'(0)})
            $display("FAIL reset_mid: got busy=%b valid=%b result=%0d, want 0 0 0", busy, valid, res);
        else passed++;
        last_res = '0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (valid || busy) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL reset_mid_quiet: got %0d active cycles, want 0", seen);
        else passed++;
        do_op(8, 12, 1'b0);
    endtask
    task automatic test_random;
        for (int i = 0; i < 30; i++)
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    endtask
    initial begin
        test_reset;
        test_basic;
        test_boundary;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
